// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares the main-memory port between the I-cache and the D-cache,
//            splitting every transfer into single-word beats. Define
//            ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed
//            D-over-I priority.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH       = 17,
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  i_cache_vis_signal,
    input  logic [ADDR_WIDTH-1:0]       i_cache_vis_addr,
    output logic [LEN-1:0]              i_cache_mem_data,
    output logic [1:0]                  i_cache_mem_status,
    input  logic [1:0]                  d_cache_vis_signal,
    input  logic [ADDR_WIDTH-1:0]       d_cache_vis_addr,
    input  logic [ENTRY_INDEX_SIZE:0]   d_cache_length,
    input  logic [LEN-1:0]              d_cache_writen_data,
    output logic [ENTRY_INDEX_SIZE-1:0] d_cache_beat,
    output logic                        d_cache_word_valid,
    output logic [LEN-1:0]              d_cache_mem_data,
    output logic [1:0]                  d_cache_mem_status,
    output logic [1:0]                  mem_vis_signal,
    output logic [ADDR_WIDTH-1:0]       mem_vis_addr,
    output logic [ENTRY_INDEX_SIZE:0]   mem_length,
    output logic [LEN-1:0]              mem_writen_data,
    input  logic [LEN-1:0]              mem_data,
    input  logic [1:0]                  mem_status
);

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_ISSUE   = 2'd1;
    localparam logic [1:0] c_S_GAP     = 2'd2;
    localparam logic [1:0] c_S_RESPOND = 2'd3;

    localparam logic [1:0] c_SIG_IDLE  = 2'b00;
    localparam logic [1:0] c_SIG_READ  = 2'b01;
    localparam logic [1:0] c_SIG_WRITE = 2'b10;

    localparam logic [1:0] c_ST_IDLE   = 2'b00;
    localparam logic [1:0] c_ST_BUSY   = 2'b01;
    localparam logic [1:0] c_ST_FIN    = 2'b10;

    localparam logic c_OWN_I = 1'b0;
    localparam logic c_OWN_D = 1'b1;

    localparam logic [ENTRY_INDEX_SIZE:0]   c_MAX_LEN  = VECTOR_SIZE[ENTRY_INDEX_SIZE:0];
    localparam logic [ENTRY_INDEX_SIZE:0]   c_LEN_ONE  = {{ENTRY_INDEX_SIZE{1'b0}}, 1'b1};
    localparam logic [ENTRY_INDEX_SIZE-1:0] c_BEAT_ONE = {{(ENTRY_INDEX_SIZE-1){1'b0}}, 1'b1};

    logic [1:0]                  state_q, state_d;
    logic                        owner_q, owner_d;
    logic [1:0]                  op_q, op_d;
    logic [ADDR_WIDTH-1:0]       base_q, base_d;
    logic [ENTRY_INDEX_SIZE:0]   len_q, len_d;
    logic [ENTRY_INDEX_SIZE-1:0] beat_q, beat_d;
    logic [1:0]                  i_status_q, i_status_d;
    logic [1:0]                  d_status_q, d_status_d;
    logic [LEN-1:0]              i_data_q;
    logic [LEN-1:0]              d_data_q;
    logic                        d_valid_q;

    logic                        w_i_req;
    logic                        w_d_req;
    logic                        w_grant_d;
    logic                        w_mem_fin;
    logic                        w_last_beat;
    logic                        w_i_closing;
    logic                        w_d_closing;
    logic [ENTRY_INDEX_SIZE:0]   w_d_len;
    logic [ADDR_WIDTH-1:0]       w_beat_addr;

    assign w_i_req     = (i_cache_vis_signal == c_SIG_READ);
    assign w_d_req     = (d_cache_vis_signal == c_SIG_READ) || (d_cache_vis_signal == c_SIG_WRITE);
    assign w_mem_fin   = (mem_status == c_ST_FIN);
    assign w_d_len     = (d_cache_length > c_MAX_LEN) ? c_MAX_LEN : d_cache_length;
    assign w_last_beat = ({1'b0, beat_q} == (len_q - c_LEN_ONE));
    assign w_beat_addr = base_q + ADDR_WIDTH'({beat_q, 2'b00});
    assign w_i_closing = (state_q == c_S_RESPOND) && (owner_q == c_OWN_I);
    assign w_d_closing = (state_q == c_S_RESPOND) && (owner_q == c_OWN_D);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    // On contention the requester that was not served last wins.
    assign w_grant_d = w_d_req && (!w_i_req || (last_grant_q == c_OWN_I));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= c_OWN_I;
        end else if ((state_q == c_S_IDLE) && (w_i_req || w_d_req)) begin
            last_grant_q <= w_grant_d;
        end
    end
`else
    assign w_grant_d = w_d_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= c_S_IDLE;
            owner_q    <= c_OWN_I;
            op_q       <= c_SIG_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            i_status_q <= c_ST_IDLE;
            d_status_q <= c_ST_IDLE;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            op_q       <= op_d;
            base_q     <= base_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            i_status_q <= i_status_d;
            d_status_q <= d_status_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        op_d    = op_q;
        base_d  = base_q;
        len_d   = len_q;
        beat_d  = beat_q;
        case (state_q)
            c_S_IDLE: begin
                if (w_i_req || w_d_req) begin
                    owner_d = w_grant_d;
                    beat_d  = '0;
                    if (w_grant_d) begin
                        op_d    = d_cache_vis_signal;
                        base_d  = d_cache_vis_addr;
                        len_d   = w_d_len;
                        state_d = (w_d_len == '0) ? c_S_RESPOND : c_S_ISSUE;
                    end else begin
                        op_d    = c_SIG_READ;
                        base_d  = i_cache_vis_addr;
                        len_d   = c_LEN_ONE;
                        state_d = c_S_ISSUE;
                    end
                end
            end
            c_S_ISSUE: begin
                if (w_mem_fin) begin
                    state_d = w_last_beat ? c_S_RESPOND : c_S_GAP;
                end
            end
            // The beat index advances on leaving GAP so d_cache_beat still
            // names the word being reported by d_cache_word_valid.
            c_S_GAP: begin
                beat_d  = beat_q + c_BEAT_ONE;
                state_d = c_S_ISSUE;
            end
            default: begin
                state_d = c_S_IDLE;
            end
        endcase

        i_status_d = c_ST_IDLE;
        if ((state_d == c_S_RESPOND) && (owner_d == c_OWN_I)) begin
            i_status_d = c_ST_FIN;
        end else if ((state_d != c_S_IDLE) && (owner_d == c_OWN_I)) begin
            i_status_d = c_ST_BUSY;
        end else if (w_i_req && !w_i_closing) begin
            i_status_d = c_ST_BUSY;
        end

        d_status_d = c_ST_IDLE;
        if ((state_d == c_S_RESPOND) && (owner_d == c_OWN_D)) begin
            d_status_d = c_ST_FIN;
        end else if ((state_d != c_S_IDLE) && (owner_d == c_OWN_D)) begin
            d_status_d = c_ST_BUSY;
        end else if (w_d_req && !w_d_closing) begin
            d_status_d = c_ST_BUSY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_data_q  <= '0;
            d_data_q  <= '0;
            d_valid_q <= 1'b0;
        end else begin
            d_valid_q <= 1'b0;
            if ((state_q == c_S_ISSUE) && w_mem_fin) begin
                if (owner_q == c_OWN_D) begin
                    d_data_q  <= mem_data;
                    d_valid_q <= (op_q == c_SIG_READ);
                end else begin
                    i_data_q <= mem_data;
                end
            end
        end
    end

    always_comb begin
        mem_vis_signal  = c_SIG_IDLE;
        mem_vis_addr    = '0;
        mem_length      = '0;
        mem_writen_data = '0;
        if (state_q == c_S_ISSUE) begin
            mem_vis_signal  = op_q;
            mem_vis_addr    = w_beat_addr;
            mem_length      = c_LEN_ONE;
            mem_writen_data = d_cache_writen_data;
        end
    end

    assign i_cache_mem_data   = i_data_q;
    assign i_cache_mem_status = i_status_q;
    assign d_cache_mem_data   = d_data_q;
    assign d_cache_mem_status = d_status_q;
    assign d_cache_word_valid = d_valid_q;
    assign d_cache_beat       = beat_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed and random transfers for mem_arbiter against a memory
//            model and a beat-level expectation of addresses, data and timing.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk, rst;
    logic [1:0]  i_sig;
    logic [16:0] i_addr;
    logic [31:0] i_rdata;
    logic [1:0]  i_stat;
    logic [1:0]  d_sig;
    logic [16:0] d_addr;
    logic [3:0]  d_len;
    logic [31:0] d_wdata;
    logic [2:0]  d_beat;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic [1:0]  d_stat;
    logic [1:0]  m_sig;
    logic [16:0] m_addr;
    logic [3:0]  m_len;
    logic [31:0] m_wdata;
    logic [31:0] m_data;
    logic [1:0]  m_stat;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [1:0]  op;
        logic [16:0] addr;
        logic [31:0] wd;
    } acc_t;

    acc_t        log_q[$];
    logic [31:0] mem_arr [0:32767];
    int          mem_lat = 0;
    logic [31:0] wr_seed = 32'h0;

    assign d_wdata = wr_seed + 32'(d_beat);

    mem_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_cache_vis_signal  (i_sig),
        .i_cache_vis_addr    (i_addr),
        .i_cache_mem_data    (i_rdata),
        .i_cache_mem_status  (i_stat),
        .d_cache_vis_signal  (d_sig),
        .d_cache_vis_addr    (d_addr),
        .d_cache_length      (d_len),
        .d_cache_writen_data (d_wdata),
        .d_cache_beat        (d_beat),
        .d_cache_word_valid  (d_valid),
        .d_cache_mem_data    (d_rdata),
        .d_cache_mem_status  (d_stat),
        .mem_vis_signal      (m_sig),
        .mem_vis_addr        (m_addr),
        .mem_length          (m_len),
        .mem_writen_data     (m_wdata),
        .mem_data            (m_data),
        .mem_status          (m_stat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rd_model(input logic [16:0] a);
        return mem_arr[a[16:2]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory: answers each request after mem_lat extra cycles with a one-cycle FINISHED.
    initial begin : mem_model
        int          lat_cnt;
        logic [16:0] a;
        acc_t        e;
        for (int k = 0; k < 32768; k++) mem_arr[k] = 32'hC0DE0000 ^ (32'(k) << 2);
        m_stat  = 2'b00;
        m_data  = 32'h0;
        lat_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            m_stat = 2'b00;
            if (rst || m_sig == 2'b00) begin
                lat_cnt = 0;
            end else if (lat_cnt >= mem_lat) begin
                lat_cnt = 0;
                m_stat  = 2'b10;
                a       = m_addr;
                if (m_sig == 2'b10) begin
                    mem_arr[a[16:2]] = m_wdata;
                    m_data = $urandom;
                end else begin
                    m_data = rd_model(a);
                end
                e.op = m_sig; e.addr = a; e.wd = m_wdata;
                log_q.push_back(e);
            end else begin
                lat_cnt++;
            end
        end
    end

    task automatic run_single(input bit is_d, input logic [1:0] op, input logic [16:0] base,
                              input logic [3:0] len, input int lat, input logic [31:0] seed,
                              input string tag);
        int eff, exp_cyc, cyc, nvalid, runs, idle_run;
        int bad_stat, bad_other, bad_bus, bad_gap, bad_word, bad_acc;
        bit done, prev_act;
        logic [1:0]  exp_op, own, oth;
        logic [16:0] ea;
        eff      = !is_d ? 1 : ((int'(len) > 8) ? 8 : int'(len));
        exp_op   = is_d ? op : 2'b01;
        exp_cyc  = (eff == 0) ? 1 : 1 + eff * (lat + 1) + (eff - 1);
        mem_lat  = lat;
        wr_seed  = seed;
        log_q.delete();
        cyc = 0; nvalid = 0; runs = 0; idle_run = 0; done = 0; prev_act = 0;
        bad_stat = 0; bad_other = 0; bad_bus = 0; bad_gap = 0; bad_word = 0; bad_acc = 0;
        if (is_d) begin d_sig = op; d_addr = base; d_len = len; end
        else begin i_sig = 2'b01; i_addr = base; end
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (m_sig != 2'b00) begin
                if (!prev_act) begin
                    if (runs > 0 && idle_run != 1) bad_gap++;
                    runs++;
                end
                if (m_sig !== exp_op || m_len !== 4'd1) bad_bus++;
                prev_act = 1; idle_run = 0;
            end else begin
                if (m_len !== 4'd0) bad_bus++;
                prev_act = 0; idle_run++;
            end
            if (d_valid) begin
                ea = base + 17'(4 * nvalid);
                if (d_beat !== 3'(nvalid) || d_rdata !== rd_model(ea)) bad_word++;
                nvalid++;
            end
            own = is_d ? d_stat : i_stat;
            oth = is_d ? i_stat : d_stat;
            if (own === 2'b10) done = 1;
            else if (own !== 2'b01) bad_stat++;
            if (oth !== 2'b00) bad_other++;
        end
        if (is_d) d_sig = 2'b00; else i_sig = 2'b00;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_latency"}, cyc, exp_cyc);
        chk({tag, "_valid_pulses"}, nvalid, (is_d && op == 2'b01) ? eff : 0);
        chk({tag, "_bus_beats"}, runs, eff);
        chk({tag, "_mem_accesses"}, log_q.size(), eff);
        foreach (log_q[k]) begin
            ea = base + 17'(4 * k);
            if (log_q[k].addr !== ea || log_q[k].op !== exp_op) bad_acc++;
            if (exp_op == 2'b10 && log_q[k].wd !== seed + 32'(k)) bad_acc++;
        end
        chk({tag, "_access_errs"}, bad_acc, 0);
        chk({tag, "_status_errs"}, bad_stat, 0);
        chk({tag, "_other_status_errs"}, bad_other, 0);
        chk({tag, "_bus_errs"}, bad_bus + bad_gap, 0);
        chk({tag, "_word_errs"}, bad_word, 0);
        if (!is_d) chk({tag, "_idata"}, i_rdata, rd_model(base));
        @(negedge clk);
        chk({tag, "_after_idle"}, {28'd0, i_stat, d_stat} | {30'd0, m_sig}, 32'd0);
    endtask

    task automatic run_pair(input logic [16:0] ia, input logic [16:0] da,
                            input bit exp_d_first, input string tag);
        int cyc, bad_i, bad_d, i_fin, d_fin;
        bit i_done, d_done;
        logic [16:0] a0, a1;
        mem_lat = 0;
        log_q.delete();
        cyc = 0; bad_i = 0; bad_d = 0; i_fin = 0; d_fin = 0; i_done = 0; d_done = 0;
        i_sig = 2'b01; i_addr = ia;
        d_sig = 2'b01; d_addr = da; d_len = 4'd1;
        while (!(i_done && d_done) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (!i_done) begin
                if (i_stat === 2'b10) begin i_done = 1; i_fin = cyc; i_sig = 2'b00; end
                else if (i_stat !== 2'b01) bad_i++;
            end
            if (!d_done) begin
                if (d_stat === 2'b10) begin d_done = 1; d_fin = cyc; d_sig = 2'b00; end
                else if (d_stat !== 2'b01) bad_d++;
            end
        end
        a0 = (log_q.size() > 0) ? log_q[0].addr : 17'h0;
        a1 = (log_q.size() > 1) ? log_q[1].addr : 17'h0;
        chk({tag, "_both_done"}, 32'({i_done, d_done}), 32'd3);
        chk({tag, "_i_busy_errs"}, bad_i, 0);
        chk({tag, "_d_busy_errs"}, bad_d, 0);
        chk({tag, "_d_first"}, 32'(d_fin < i_fin), 32'(exp_d_first));
        chk({tag, "_first_addr"}, 32'(a0), 32'(exp_d_first ? da : ia));
        chk({tag, "_second_addr"}, 32'(a1), 32'(exp_d_first ? ia : da));
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin : stim
        int          bad, found;
        bit          is_d;
        logic [1:0]  op;
        logic [16:0] base;
        rst = 1'b1;
        i_sig = 2'b00; i_addr = '0;
        d_sig = 2'b00; d_addr = '0; d_len = '0;
        repeat (2) @(negedge clk);

        chk("rst_mem_sig", 32'(m_sig), 32'd0);
        chk("rst_mem_len", 32'(m_len), 32'd0);
        chk("rst_mem_addr", 32'(m_addr), 32'd0);
        chk("rst_mem_wdata", m_wdata, 32'd0);
        chk("rst_status", 32'({i_stat, d_stat}), 32'd0);
        chk("rst_beat_valid", 32'({d_beat, d_valid}), 32'd0);
        chk("rst_data", i_rdata | d_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Encodings 10 (I) and 11 (D) must be ignored.
        i_sig = 2'b10; d_sig = 2'b11; d_len = 4'd2; bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (m_sig !== 2'b00 || i_stat !== 2'b00 || d_stat !== 2'b00) bad++;
        end
        i_sig = 2'b00; d_sig = 2'b00;
        chk("bad_encoding_ignored", bad, 0);

        mem_arr[17'h00010 >> 2] = 32'hDEADBEEF;
        run_single(1'b0, 2'b01, 17'h00010, 4'd1, 2, 32'h0, "i_read_10");
        chk("i_read_deadbeef", i_rdata, 32'hDEADBEEF);

        pulse_reset();
        run_pair(17'h00040, 17'h00200, 1'b1, "pair1");
        run_single(1'b1, 2'b01, 17'h00180, 4'd1, 0, 32'h0, "d_single");
        run_pair(17'h00044, 17'h00204, !RR, "pair2");

        run_single(1'b1, 2'b01, 17'h00100, 4'd8, 0, 32'h0, "d_read8");
        run_single(1'b1, 2'b10, 17'h00080, 4'd4, 1, 32'hA0, "d_write4");
        chk("mem_8c", mem_arr[17'h0008C >> 2], 32'hA3);
        run_single(1'b1, 2'b01, 17'h00080, 4'd4, 0, 32'h0, "d_readback4");
        chk("readback_last", d_rdata, 32'hA3);
        run_single(1'b1, 2'b01, 17'h00300, 4'd0, 0, 32'h0, "d_len0");
        run_single(1'b1, 2'b01, 17'h00400, 4'd12, 1, 32'h0, "d_len12");
        run_single(1'b1, 2'b10, 17'h1FFF8, 4'd4, 0, 32'h55, "d_wrap");

        // Reset during beat 3 of an 8-beat read.
        mem_lat = 1;
        log_q.delete();
        d_sig = 2'b01; d_addr = 17'h00500; d_len = 4'd8; found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            @(negedge clk);
            if (d_beat == 3'd3 && m_sig != 2'b00) found = 1;
        end
        chk("mid_reset_reached_beat3", found, 1);
        rst = 1'b1;
        #1;
        chk("mid_reset_ctl", 32'({m_sig, m_len, i_stat, d_stat, d_beat, d_valid}), 32'd0);
        chk("mid_reset_addr", 32'(m_addr), 32'd0);
        chk("mid_reset_wdata", m_wdata, 32'd0);
        chk("mid_reset_data", i_rdata | d_rdata, 32'd0);
        d_sig = 2'b00; bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (d_stat === 2'b10) bad++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (d_stat === 2'b10) bad++;
        end
        chk("mid_reset_no_finish", bad, 0);
        run_single(1'b0, 2'b01, 17'h00000, 4'd1, 0, 32'h0, "post_reset_i");
        chk("post_reset_beat", 32'(d_beat), 32'd0);

        for (int t = 0; t < 24; t++) begin
            is_d = ($urandom_range(0, 3) != 0);
            op   = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
            base = 17'($urandom_range(0, 32'h1FFFF)) & ~17'h3;
            if (t % 6 == 5) base = 17'h1FFF0;
            run_single(is_d, op, base, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                       $urandom, $sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
